// File: rtl/red_laser_controller.sv
// Alien laser shot tracker: launch, per-frame fall, collision/off-screen end, cooldown,
// plus a registered scan-position rectangle test feeding the bitmap stage.
module red_laser_controller #(
    parameter int OBJECT_WIDTH_X  = 64,
    parameter int OBJECT_HEIGHT_Y = 64,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int SPEED_Y         = 4,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] fireX,
    input  logic [10:0] fireY,
    input  logic        collision,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        laserActive,
    output logic        readyToFire
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FLYING = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   top_left_x_q, top_left_x_d;
    logic [10:0]   top_left_y_q, top_left_y_d;
    logic [CW-1:0] cooldown_q, cooldown_d;
    logic          laser_active_q, laser_active_d;
    logic          ready_q, ready_d;
    logic          inside_q, inside_d;
    logic [10:0]   offset_x_q, offset_x_d;
    logic [10:0]   offset_y_q, offset_y_d;

    logic [11:0]   next_y;
    logic [11:0]   x_end, y_end;

    always_comb begin
        state_d      = state_q;
        top_left_x_d = top_left_x_q;
        top_left_y_d = top_left_y_q;
        cooldown_d   = cooldown_q;
        next_y       = {1'b0, top_left_y_q} + 12'(SPEED_Y);

        case (state_q)
            IDLE: begin
                if (fire && cooldown_q == '0) begin
                    state_d      = ARMED;
                    top_left_x_d = (fireX > 11'(SCREEN_WIDTH - OBJECT_WIDTH_X))
                                   ? 11'(SCREEN_WIDTH - OBJECT_WIDTH_X) : fireX;
                    top_left_y_d = fireY;
                end else if (startOfFrame && cooldown_q != '0) begin
                    cooldown_d = cooldown_q - 1'b1;
                end
            end
            ARMED: begin
                // First frame only arms; the shot starts moving on the following frame.
                if (startOfFrame)
                    state_d = FLYING;
            end
            FLYING: begin
                if (collision) begin
                    state_d    = IDLE;
                    cooldown_d = CW'(COOLDOWN_FRAMES);
                end else if (startOfFrame) begin
                    if (next_y >= 12'(SCREEN_HEIGHT)) begin
                        state_d    = IDLE;
                        cooldown_d = CW'(COOLDOWN_FRAMES);
                    end else begin
                        top_left_y_d = next_y[10:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        laser_active_d = (state_d != IDLE);
        ready_d        = (state_d == IDLE) && (cooldown_d == '0);
    end

    // Rectangle test uses the registered position so it lines up with the bitmap register.
    always_comb begin
        x_end      = {1'b0, top_left_x_q} + 12'(OBJECT_WIDTH_X);
        y_end      = {1'b0, top_left_y_q} + 12'(OBJECT_HEIGHT_Y);
        inside_d   = laser_active_q
                     && (pixelX >= top_left_x_q) && ({1'b0, pixelX} < x_end)
                     && (pixelY >= top_left_y_q) && ({1'b0, pixelY} < y_end);
        offset_x_d = inside_d ? (pixelX - top_left_x_q) : 11'd0;
        offset_y_d = inside_d ? (pixelY - top_left_y_q) : 11'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            top_left_x_q   <= '0;
            top_left_y_q   <= '0;
            cooldown_q     <= '0;
            laser_active_q <= 1'b0;
            ready_q        <= 1'b0;
            inside_q       <= 1'b0;
            offset_x_q     <= '0;
            offset_y_q     <= '0;
        end else begin
            state_q        <= state_d;
            top_left_x_q   <= top_left_x_d;
            top_left_y_q   <= top_left_y_d;
            cooldown_q     <= cooldown_d;
            laser_active_q <= laser_active_d;
            ready_q        <= ready_d;
            inside_q       <= inside_d;
            offset_x_q     <= offset_x_d;
            offset_y_q     <= offset_y_d;
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign topLeftX        = top_left_x_q;
    assign topLeftY        = top_left_y_q;
    assign laserActive     = laser_active_q;
    assign readyToFire     = ready_q;

endmodule
